locked_restoring_divider16: RTL
===============================

// Module: locked_restoring_divider16
// PURPOSE
//  Key-locked sequential restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient, 8-bit remainder.
//  Inverse-direction companion of the locked array multiplier in the 64xor suite; used for locked-netlist key-sweep simulation.
//  A wrong key corrupts the effective divisor and the quotient deterministically, so benches can predict the corrupted values exactly.
// PARAMETERS
//  KEY_W        16        keyinput width
//  KEY_CORRECT  16'hB327  unlocking key; lock_err = keyinput ^ KEY_CORRECT
//  ITER         16        restoring iterations = dividend width
// PORTS
//  clk_i        in   1    single clock, rising edge
//  rst_i        in   1    synchronous, active-high reset
//  start_i      in   1    request; accepted only when busy_o==0
//  dividend_i   in   16   dividend, sampled on accept
//  divisor_i    in   8    divisor, sampled on accept
//  keyinput     in   16   lock key, sampled on accept
//  busy_o       out  1    high in CALC and in the cycle after accept
//  done_o       out  1    one-cycle pulse: results valid
//  quotient_o   out  16   quotient (key-masked), held until next accept
//  remainder_o  out  8    remainder, held until next accept
//  div_by_zero_o out 1    effective divisor was 0; held with results
// BEHAVIOUR
//  Reset: state=IDLE; busy_o, done_o, div_by_zero_o = 0; quotient_o, remainder_o = 0.
//  rst_i mid-operation: same values on the next edge, in-flight result discarded, no done_o.
//  States:
//   - IDLE: start_i -> latch operands and key; ld=lock_err latched, d_eff = divisor_i ^ ld[7:0].
//     d_eff==0 -> DONE, else CALC with cnt=0, r=0, q=dividend.
//   - CALC: per cycle r9={r[7:0],q[15]}, q<<=1; if r9>=d_eff then r=r9-d_eff, q[0]=1, else r=r9[7:0]; cnt++.
//     Exit to DONE when cnt==ITER-1.
//   - DONE: done_o=1 for exactly this cycle; busy_o=0. quotient_o = q ^ {ld[15:8],ld[15:8]}, remainder_o = r.
//     Next state IDLE; start_i here is accepted like IDLE (back-to-back ops).
//  Timing:
//   - Latency: accept at edge t -> done_o high in cycle t+17 (16 CALC + DONE).
//   - Div-by-zero: done_o at t+1 with quotient_o=16'hFFFF (unmasked), remainder_o=dividend[7:0], div_by_zero_o=1.
//  Rules:
//   - div_by_zero_o is cleared on the next accept.
//   - start_i while busy_o=1 is ignored; no queueing.
//   - Input changes after accept have no effect; keyinput is sampled once per op.
//   - Remainder width: r9 is 9 bits, so the compare is unsigned and overflow-free. Outputs change only in DONE or on reset.
// STRUCTURE
//  Package locked_div_pkg: state enum {IDLE,CALC,DONE}, DIVIDEND_W=16, DIVISOR_W=8, KEY_W, KEY_CORRECT.
//  Sub-module div_step (combinational): one restoring iteration (r, q, d) -> (r', q'). FSM, counter and registers stay in the top.
// TESTING
//  1. keyinput=B327, 1A2B/37 -> done_o at t+17; quotient_o=0079, remainder_o=2C, div_by_zero_o=0.
//  2. keyinput=B337 (lock_err=0010), 1A2B/37 -> d_eff=27; quotient_o=00AB, remainder_o=1E.
//  3. keyinput=B327, FFFF/01 -> FFFF rem 00; FFFF/FF -> 0101 rem 00.
//     keyinput=7327 (lock_err=C000), 1A2B/37 -> quotient_o=0079^C0C0=C0B9.
//  4. keyinput=B327, 1234/00 -> done_o at t+1; FFFF, rem 34, div_by_zero_o=1.
//     A following 0064/0A -> div_by_zero_o=0, quotient_o=000A, remainder_o=00.
//  5. start_i held high during CALC with new operands -> ignored, first result unchanged.
//     start_i in the DONE cycle -> second op accepted; its done_o 17 cycles later.
//  6. rst_i at CALC cycle 8 -> next cycle all outputs 0, state IDLE, no done_o. A fresh op afterwards completes correctly.

Source files
------------

// File: rtl/locked_div_pkg.sv
// Shared types and constants for the key-locked restoring divider.
//   state_e     : divider FSM states
//   DIVIDEND_W  : dividend / quotient width
//   DIVISOR_W   : divisor / remainder width
//   KEY_W       : lock key width
//   KEY_CORRECT : unlocking key (lock error = key ^ KEY_CORRECT)
//   key_mask()  : expands the upper lock-error byte into the quotient mask
package locked_div_pkg;

  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;
  localparam int unsigned KEY_W      = 16;

  localparam logic [KEY_W-1:0] KEY_CORRECT = 16'hB327;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Upper lock-error byte replicated across the quotient.
  function automatic logic [DIVIDEND_W-1:0] key_mask(input logic [DIVISOR_W-1:0] hi);
    return {hi, hi};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   r_i      : partial remainder in
//   q_i      : shifting dividend / quotient register in
//   d_i      : effective divisor
//   r_o      : partial remainder out
//   q_o      : dividend / quotient register out (new quotient bit in LSB)
module div_step
  import locked_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0]  r_i,
  input  logic [DIVIDEND_W-1:0] q_i,
  input  logic [DIVISOR_W-1:0]  d_i,
  output logic [DIVISOR_W-1:0]  r_o,
  output logic [DIVIDEND_W-1:0] q_o
);

  // One extra bit so the shifted remainder never overflows before the compare.
  logic [DIVISOR_W:0] r9;
  logic [DIVISOR_W:0] diff;
  logic               ge;

  always_comb begin
    r9   = {r_i, q_i[DIVIDEND_W-1]};
    ge   = (r9 >= {1'b0, d_i});
    diff = r9 - {1'b0, d_i};
    r_o  = ge ? diff[DIVISOR_W-1:0] : r9[DIVISOR_W-1:0];
    q_o  = {q_i[DIVIDEND_W-2:0], ge};
  end

endmodule

// File: rtl/locked_restoring_divider16.sv
// Key-locked sequential restoring divider, 16-bit dividend / 8-bit divisor.
// A wrong key XORs the low lock-error byte into the divisor and the high byte
// (replicated) into the quotient, so corrupted results are fully predictable.
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   start_i       : request, accepted when not busy (IDLE or DONE)
//   dividend_i    : dividend, sampled on accept
//   divisor_i     : divisor, sampled on accept
//   keyinput      : lock key, sampled on accept
//   busy_o        : iteration in progress
//   done_o        : one-cycle pulse, results valid
//   quotient_o    : key-masked quotient, held until the next result
//   remainder_o   : remainder, held until the next result
//   div_by_zero_o : effective divisor was zero
module locked_restoring_divider16
  import locked_div_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_CORRECT = locked_div_pkg::KEY_CORRECT,
  parameter int unsigned      ITER        = DIVIDEND_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  input  logic [KEY_W-1:0]      keyinput,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  d_q, d_d;
  logic [DIVISOR_W-1:0]  mask_q, mask_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [KEY_W-1:0]      lock_err;
  logic [DIVISOR_W-1:0]  d_in;
  logic [DIVISOR_W-1:0]  r_step;
  logic [DIVIDEND_W-1:0] q_step;

  div_step u_div_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_step),
    .q_o (q_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    mask_d   = mask_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    lock_err = keyinput ^ KEY_CORRECT;
    d_in     = divisor_i ^ lock_err[DIVISOR_W-1:0];

    unique case (state_q)
      // DONE accepts exactly like IDLE so operations can run back to back.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          mask_d = lock_err[KEY_W-1:KEY_W-DIVISOR_W];
          d_d    = d_in;
          dbz_d  = (d_in == '0);
          if (d_in == '0) begin
            // Zero divisor skips iteration; quotient is all-ones, unmasked.
            state_d = StDone;
            quot_d  = '1;
            rem_d   = dividend_i[DIVISOR_W-1:0];
          end else begin
            state_d = StCalc;
            cnt_d   = '0;
            r_d     = '0;
            q_d     = dividend_i;
          end
        end
      end
      StCalc: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          quot_d  = q_step ^ key_mask(mask_q);
          rem_d   = r_step;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      mask_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      mask_q  <= mask_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q == StCalc);
  assign done_o        = (state_q == StDone);
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule
